// File: rtl/helios_stream_pkg.sv
// helios_stream_pkg: shared frame header, serializer state type and round-size helper.
package helios_stream_pkg;
  localparam logic [7:0] FRAME_HEADER = 8'h01;
  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_WAIT_ROUND,
    S_TRAILER
  } state_t;
  function automatic int bytes_per_round(input int bits);
    return (bits + 7) / 8;
  endfunction
endpackage

// File: rtl/syndrome_stream_serializer_if.sv
// syndrome_stream_serializer_if: round input handshake plus decoder byte stream.
interface syndrome_stream_serializer_if #(parameter int ROUND_BITS = 4);
  logic [ROUND_BITS-1:0] round_data;
  logic                  round_valid;
  logic                  round_ready;
  logic [7:0]            out_data;
  logic                  out_valid;
  logic                  out_ready;
  modport master (output round_data, round_valid, out_ready, input round_ready, out_data, out_valid);
  modport slave  (input round_data, round_valid, out_ready, output round_ready, out_data, out_valid);
endinterface

// File: rtl/stream_output_reg.sv
// stream_output_reg: 8-bit data/valid register slice that holds its byte under backpressure.
module stream_output_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data
);
  logic       r_valid;
  logic [7:0] r_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
    end else if (!r_valid || i_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/syndrome_stream_serializer.sv
// syndrome_stream_serializer: packs GRID_WIDTH_U syndrome rounds into header+data byte frames.
// Define SERIALIZER_PARITY_EN to append an XOR-of-data-bytes trailer to each frame.
module syndrome_stream_serializer
  import helios_stream_pkg::*;
#(
  parameter int GRID_WIDTH_X = 4,
  parameter int GRID_WIDTH_Z = 1,
  parameter int GRID_WIDTH_U = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  syndrome_stream_serializer_if.slave  s_if,
  output logic                         o_frame_active,
  output logic [15:0]                  o_frames_sent
);
  localparam int RB = GRID_WIDTH_X * GRID_WIDTH_Z;
  localparam int B  = bytes_per_round(RB);
  localparam int RW = GRID_WIDTH_U > 1 ? $clog2(GRID_WIDTH_U) : 1;
  localparam int BW = B > 1 ? $clog2(B) : 1;
`ifdef SERIALIZER_PARITY_EN
  localparam state_t END_STATE = S_TRAILER;
`else
  localparam state_t END_STATE = S_IDLE;
`endif

  state_t          r_state, w_next;
  logic [RB-1:0]   r_hold;
  logic [RW-1:0]   r_round_idx;
  logic [BW-1:0]   r_byte_idx, w_next_idx;
  logic [8*B-1:0]  w_hold_pad;
  logic [7:0]      w_in_byte, w_byte;
  logic            w_hs, w_rhs, w_last_byte, w_last_round, w_final, w_push;
  logic            r_active;
  logic [15:0]     r_frames_sent;
`ifdef SERIALIZER_PARITY_EN
  logic [7:0]      r_par;
`endif

  // Holding bits above ROUND_BITS read as zero in the last byte of a round.
  assign w_hold_pad   = (8*B)'(r_hold);
  assign w_in_byte    = 8'(s_if.round_data);
  assign w_next_idx   = r_byte_idx + 1'b1;
  assign w_last_byte  = r_byte_idx == BW'(B - 1);
  assign w_last_round = r_round_idx == RW'(GRID_WIDTH_U - 1);
  assign w_hs         = s_if.out_valid && s_if.out_ready;
  assign s_if.round_ready = (r_state == S_IDLE) || (r_state == S_WAIT_ROUND);
  assign w_rhs        = s_if.round_valid && s_if.round_ready;
`ifdef SERIALIZER_PARITY_EN
  assign w_final = (r_state == S_TRAILER) && w_hs;
`else
  assign w_final = (r_state == S_DATA) && w_hs && w_last_byte && w_last_round;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       w_next = w_rhs ? S_HEADER : S_IDLE;
      S_HEADER:     w_next = w_hs ? S_DATA : S_HEADER;
      S_DATA:       w_next = !(w_hs && w_last_byte) ? S_DATA : w_last_round ? END_STATE : S_WAIT_ROUND;
      S_WAIT_ROUND: w_next = w_rhs ? S_DATA : S_WAIT_ROUND;
      S_TRAILER:    w_next = w_hs ? S_IDLE : S_TRAILER;
      default:      w_next = S_IDLE;
    endcase
  end

  // Next byte is loaded into the output slice on the same edge that retires the current one.
  always_comb begin
    w_push = 1'b0;
    w_byte = 8'h00;
    case (r_state)
      S_IDLE: begin
        w_push = w_rhs;
        w_byte = FRAME_HEADER;
      end
      S_HEADER: begin
        w_push = w_hs;
        w_byte = w_hold_pad[7:0];
      end
      S_DATA: begin
        w_push = w_hs && !w_last_byte;
        w_byte = w_hold_pad[{w_next_idx, 3'b000} +: 8];
`ifdef SERIALIZER_PARITY_EN
        if (w_hs && w_last_byte && w_last_round) begin
          w_push = 1'b1;
          w_byte = r_par ^ s_if.out_data;
        end
`endif
      end
      S_WAIT_ROUND: begin
        w_push = w_rhs;
        w_byte = w_in_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold        <= '0;
      r_round_idx   <= '0;
      r_byte_idx    <= '0;
      r_active      <= 1'b0;
      r_frames_sent <= 16'h0000;
`ifdef SERIALIZER_PARITY_EN
      r_par         <= 8'h00;
`endif
    end else begin
      if (w_rhs) begin
        r_hold     <= s_if.round_data;
        r_byte_idx <= '0;
      end
      if (r_state == S_IDLE && w_rhs) begin
        r_round_idx <= '0;
        r_active    <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
        r_par       <= 8'h00;
`endif
      end
      if (r_state == S_DATA && w_hs) begin
`ifdef SERIALIZER_PARITY_EN
        r_par <= r_par ^ s_if.out_data;
`endif
        if (w_last_byte) begin
          r_byte_idx <= '0;
          if (!w_last_round) r_round_idx <= r_round_idx + 1'b1;
        end else begin
          r_byte_idx <= w_next_idx;
        end
      end
      if (w_final) begin
        r_active      <= 1'b0;
        r_frames_sent <= r_frames_sent + 16'h0001;
      end
    end
  end

  stream_output_reg u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_push),
    .i_data  (w_byte),
    .i_ready (s_if.out_ready),
    .o_valid (s_if.out_valid),
    .o_data  (s_if.out_data)
  );

  assign o_frame_active = r_active;
  assign o_frames_sent  = r_frames_sent;
endmodule

// File: tb/tb_syndrome_stream_serializer.sv
// tb_syndrome_stream_serializer: directed checks on a 4x1x3 and a 10x1x1 serializer.
module tb_syndrome_stream_serializer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic        a_act, b_act;
  logic [15:0] a_cnt, b_cnt;
  logic [7:0]  by;
  bit          ok;

  syndrome_stream_serializer_if #(.ROUND_BITS(4))  ia ();
  syndrome_stream_serializer_if #(.ROUND_BITS(10)) ib ();

  syndrome_stream_serializer #(.GRID_WIDTH_X(4), .GRID_WIDTH_Z(1), .GRID_WIDTH_U(3)) u_a (
    .clk(clk), .rst_n(rst_n), .s_if(ia), .o_frame_active(a_act), .o_frames_sent(a_cnt));
  syndrome_stream_serializer #(.GRID_WIDTH_X(10), .GRID_WIDTH_Z(1), .GRID_WIDTH_U(1)) u_b (
    .clk(clk), .rst_n(rst_n), .s_if(ib), .o_frame_active(b_act), .o_frames_sent(b_cnt));

  always #5 clk = ~clk;

  task automatic push_a(input logic [3:0] d, output bit done);
    done = 1'b0;
    ia.round_data = d;
    ia.round_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ia.round_ready) done = 1'b1;
      @(negedge clk);
    end
    ia.round_valid = 1'b0;
  endtask

  task automatic push_b(input logic [9:0] d, output bit done);
    done = 1'b0;
    ib.round_data = d;
    ib.round_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ib.round_ready) done = 1'b1;
      @(negedge clk);
    end
    ib.round_valid = 1'b0;
  endtask

  task automatic get_a(output logic [7:0] b, output bit done);
    done = 1'b0;
    b = 8'h00;
    ia.out_ready = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ia.out_valid) begin
        b = ia.out_data;
        done = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic get_b(output logic [7:0] b, output bit done);
    done = 1'b0;
    b = 8'h00;
    ib.out_ready = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ib.out_valid) begin
        b = ib.out_data;
        done = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ia.round_valid = 1'b0; ia.round_data = '0; ia.out_ready = 1'b1;
    ib.round_valid = 1'b0; ib.round_data = '0; ib.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ia.out_valid, ia.out_data, a_act, a_cnt} !== 26'h0) begin
      errors++; $display("FAIL reset_a got v=%b d=%h act=%b cnt=%h exp 0/00/0/0000", ia.out_valid, ia.out_data, a_act, a_cnt);
    end
    checks++;
    if ({ib.out_valid, ib.out_data, b_act, b_cnt} !== 26'h0) begin
      errors++; $display("FAIL reset_b got v=%b d=%h act=%b cnt=%h exp 0/00/0/0000", ib.out_valid, ib.out_data, b_act, b_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ia.round_ready, ib.round_ready, ia.out_valid} !== 3'b110) begin
      errors++; $display("FAIL reset_release got rr_a=%b rr_b=%b v=%b exp 1 1 0", ia.round_ready, ib.round_ready, ia.out_valid);
    end
  endtask

  task automatic test_basic_frame();
    push_a(4'hA, ok);
    checks++;
    if ({ok, ia.out_valid, ia.round_ready, a_act, ia.out_data} !== {4'b1101, 8'h01}) begin
      errors++; $display("FAIL basic_header got ok=%b v=%b rr=%b act=%b d=%h exp 1 1 0 1 01", ok, ia.out_valid, ia.round_ready, a_act, ia.out_data);
    end
    get_a(by, ok);
    get_a(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h0A}) begin errors++; $display("FAIL basic_byte0 got %b/%h exp 1/0A", ok, by); end
    checks++;
    if ({ia.round_ready, ia.out_valid, a_act} !== 3'b101) begin
      errors++; $display("FAIL basic_wait got rr=%b v=%b act=%b exp 1 0 1", ia.round_ready, ia.out_valid, a_act);
    end
    push_a(4'h5, ok);
    get_a(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h05}) begin errors++; $display("FAIL basic_byte1 got %b/%h exp 1/05", ok, by); end
    push_a(4'hF, ok);
    get_a(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h0F}) begin errors++; $display("FAIL basic_byte2 got %b/%h exp 1/0F", ok, by); end
`ifdef SERIALIZER_PARITY_EN
    get_a(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h00}) begin errors++; $display("FAIL basic_trailer got %b/%h exp 1/00", ok, by); end
`endif
    checks++;
    if ({a_cnt, a_act, ia.out_valid} !== {16'h0001, 2'b00}) begin
      errors++; $display("FAIL basic_done got cnt=%h act=%b v=%b exp 0001 0 0", a_cnt, a_act, ia.out_valid);
    end
  endtask

  task automatic test_wide_round();
    push_b(10'h3FF, ok);
    get_b(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h01}) begin errors++; $display("FAIL wide_header got %b/%h exp 1/01", ok, by); end
    get_b(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL wide_byte0 got %b/%h exp 1/FF", ok, by); end
    get_b(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h03}) begin errors++; $display("FAIL wide_byte1 got %b/%h exp 1/03", ok, by); end
`ifdef SERIALIZER_PARITY_EN
    get_b(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'hFC}) begin errors++; $display("FAIL wide_trailer got %b/%h exp 1/FC", ok, by); end
`endif
    checks++;
    if ({b_cnt, b_act} !== {16'h0001, 1'b0}) begin
      errors++; $display("FAIL wide_done got cnt=%h act=%b exp 0001 0", b_cnt, b_act);
    end
  endtask

  task automatic test_backpressure();
    push_a(4'h3, ok);
    get_a(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h01}) begin errors++; $display("FAIL bp_header got %b/%h exp 1/01", ok, by); end
    ia.out_ready = 1'b0;
    ia.round_data = 4'hC;
    ia.round_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({ia.out_valid, ia.out_data, ia.round_ready} !== {1'b1, 8'h03, 1'b0}) begin
        errors++; $display("FAIL bp_stall%0d got v=%b d=%h rr=%b exp 1 03 0", i, ia.out_valid, ia.out_data, ia.round_ready);
      end
    end
    get_a(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h03}) begin errors++; $display("FAIL bp_byte0 got %b/%h exp 1/03", ok, by); end
    checks++;
    if ({ia.round_ready, ia.out_valid} !== 2'b10) begin
      errors++; $display("FAIL bp_wait got rr=%b v=%b exp 1 0", ia.round_ready, ia.out_valid);
    end
    @(negedge clk);
    ia.round_valid = 1'b0;
    get_a(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h0C}) begin errors++; $display("FAIL bp_byte1 got %b/%h exp 1/0C", ok, by); end
    push_a(4'h6, ok);
    get_a(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h06}) begin errors++; $display("FAIL bp_byte2 got %b/%h exp 1/06", ok, by); end
`ifdef SERIALIZER_PARITY_EN
    get_a(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h09}) begin errors++; $display("FAIL bp_trailer got %b/%h exp 1/09", ok, by); end
`endif
    checks++;
    if (a_cnt !== 16'h0002) begin errors++; $display("FAIL bp_count got %h exp 0002", a_cnt); end
  endtask

  task automatic test_midframe_reset();
    push_a(4'h1, ok);
    get_a(by, ok);
    get_a(by, ok);
    ia.out_ready = 1'b0;
    push_a(4'h2, ok);
    checks++;
    if ({ia.out_valid, ia.out_data} !== {1'b1, 8'h02}) begin
      errors++; $display("FAIL mid_pre got v=%b d=%h exp 1 02", ia.out_valid, ia.out_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ia.out_valid, a_act, a_cnt, b_cnt} !== 34'h0) begin
      errors++; $display("FAIL mid_async got v=%b act=%b cnt_a=%h cnt_b=%h exp 0 0 0000 0000", ia.out_valid, a_act, a_cnt, b_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ia.out_ready = 1'b1;
    @(negedge clk);
    push_a(4'h7, ok);
    checks++;
    if ({ok, ia.out_valid, ia.out_data} !== {2'b11, 8'h01}) begin
      errors++; $display("FAIL mid_restart got ok=%b v=%b d=%h exp 1 1 01", ok, ia.out_valid, ia.out_data);
    end
    get_a(by, ok);
    get_a(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h07}) begin errors++; $display("FAIL mid_byte0 got %b/%h exp 1/07", ok, by); end
    push_a(4'h8, ok);
    get_a(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h08}) begin errors++; $display("FAIL mid_byte1 got %b/%h exp 1/08", ok, by); end
    push_a(4'h9, ok);
    get_a(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h09}) begin errors++; $display("FAIL mid_byte2 got %b/%h exp 1/09", ok, by); end
`ifdef SERIALIZER_PARITY_EN
    get_a(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h06}) begin errors++; $display("FAIL mid_trailer got %b/%h exp 1/06", ok, by); end
`endif
    checks++;
    if ({a_cnt, a_act} !== {16'h0001, 1'b0}) begin
      errors++; $display("FAIL mid_done got cnt=%h act=%b exp 0001 0", a_cnt, a_act);
    end
  endtask

  task automatic test_count_wrap();
    @(negedge clk);
    force u_b.r_frames_sent = 16'hFFFF;
    @(negedge clk);
    release u_b.r_frames_sent;
    @(negedge clk);
    checks++;
    if (b_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset got %h exp FFFF", b_cnt); end
    push_b(10'h155, ok);
    get_b(by, ok);
    get_b(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h55}) begin errors++; $display("FAIL wrap_byte0 got %b/%h exp 1/55", ok, by); end
    get_b(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h01}) begin errors++; $display("FAIL wrap_byte1 got %b/%h exp 1/01", ok, by); end
`ifdef SERIALIZER_PARITY_EN
    get_b(by, ok);
    checks++;
    if ({ok, by} !== {1'b1, 8'h54}) begin errors++; $display("FAIL wrap_trailer got %b/%h exp 1/54", ok, by); end
`endif
    checks++;
    if (b_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_count got %h exp 0000", b_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_wide_round();
    test_backpressure();
    test_midframe_reset();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
